// File: rtl/fifo_skip_sa.sv
// Single-clock synchronous FIFO with multi-word skip reads, occupancy
// counter, programmable almost-full/almost-empty flags, optional show-ahead
// read port and registered overflow/underflow pulses.
module fifo_skip_sa #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned AWIDTH     = 4,
  parameter int unsigned SWIDTH     = 2,
  parameter int unsigned SHOWAHEAD  = 0,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_i,
  input  logic [DWIDTH-1:0] wrdata_i,
  input  logic              rd_i,
  input  logic [SWIDTH-1:0] skip_i,
  output logic [DWIDTH-1:0] rddata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned     DEPTH    = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W  = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_W  = (AWIDTH + 1)'(AFULL_LVL);
  localparam logic [AWIDTH:0] AEMPTY_W = (AWIDTH + 1)'(AEMPTY_LVL);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] wrptr_q, wrptr_d;
  logic [AWIDTH-1:0] rdptr_q, rdptr_d;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              rd_acc;
  logic              wr_acc;
  logic [AWIDTH:0]   skip_cnt;
  logic [AWIDTH:0]   rd_cnt;

  // Accept logic, skip clamping, pointer/occupancy and flag next-state.
  always_comb begin
    rd_acc   = rd_i & ~empty_q;
    skip_cnt = (AWIDTH + 1)'(skip_i) + (AWIDTH + 1)'(1);
    rd_cnt   = '0;
    if (rd_acc) begin
      rd_cnt = (skip_cnt > usedw_q) ? usedw_q : skip_cnt;
    end
    wr_acc   = wr_i & (~full_q | rd_acc);
    wrptr_d  = wrptr_q + AWIDTH'(wr_acc);
    rdptr_d  = rdptr_q + rd_cnt[AWIDTH-1:0];
    usedw_d  = usedw_q + (AWIDTH + 1)'(wr_acc) - rd_cnt;
    empty_d  = (usedw_d == '0);
    full_d   = (usedw_d == DEPTH_W);
    afull_d  = (usedw_d >= AFULL_W);
    aempty_d = (usedw_d <= AEMPTY_W);
    ovf_d    = wr_i & ~wr_acc;
    unf_d    = rd_i & empty_q;
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wrptr_q  <= wrptr_d;
      rdptr_q  <= rdptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array, not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (srst_i && wr_acc) begin
      mem_q[wrptr_q] <= wrdata_i;
    end
  end

  generate
    if (SHOWAHEAD == 0) begin : g_reg_rd
      logic [DWIDTH-1:0] rddata_q, rddata_d;

      // Registered read port returns the oldest consumed word.
      always_comb begin
        rddata_d = rddata_q;
        if (rd_acc) begin
          rddata_d = mem_q[rdptr_q];
        end
      end

      // Read data register.
      always_ff @(posedge clk_i) begin
        if (!srst_i) begin
          rddata_q <= '0;
        end else begin
          rddata_q <= rddata_d;
        end
      end

      assign rddata_o = rddata_q;
    end else begin : g_show_ahead
      // Head word presented combinationally from the register array.
      always_comb begin
        rddata_o = mem_q[rdptr_q];
      end
    end
  endgenerate

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign usedw_o        = usedw_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_skip_sa.sv
// Bench for fifo_skip_sa: directed scenarios plus randomized traffic checked
// against a queue-based reference model; a registered-read and a show-ahead
// instance share the same stimulus.
module tb_fifo_skip_sa;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int SW    = 2;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          wr = 1'b0;
  logic [DW-1:0] wrdata = '0;
  logic          rd = 1'b0;
  logic [SW-1:0] skip = '0;

  logic [DW-1:0] rddata, rddata_sa;
  logic          empty, full, afull, aempty, ovf, unf;
  logic          empty_sa, full_sa, afull_sa, aempty_sa, ovf_sa, unf_sa;
  logic [AW:0]   usedw, usedw_sa;
  logic [5:0]    flags, flags_sa;

  assign flags    = {empty, full, afull, aempty, ovf, unf};
  assign flags_sa = {empty_sa, full_sa, afull_sa, aempty_sa, ovf_sa, unf_sa};

  fifo_skip_sa #(
    .DWIDTH(DW), .AWIDTH(AW), .SWIDTH(SW), .SHOWAHEAD(0),
    .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .clk_i(clk), .srst_i(srst), .wr_i(wr), .wrdata_i(wrdata), .rd_i(rd),
    .skip_i(skip), .rddata_o(rddata), .empty_o(empty), .full_o(full),
    .almost_full_o(afull), .almost_empty_o(aempty), .usedw_o(usedw),
    .overflow_o(ovf), .underflow_o(unf)
  );

  fifo_skip_sa #(
    .DWIDTH(DW), .AWIDTH(AW), .SWIDTH(SW), .SHOWAHEAD(1),
    .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut_sa (
    .clk_i(clk), .srst_i(srst), .wr_i(wr), .wrdata_i(wrdata), .rd_i(rd),
    .skip_i(skip), .rddata_o(rddata_sa), .empty_o(empty_sa), .full_o(full_sa),
    .almost_full_o(afull_sa), .almost_empty_o(aempty_sa), .usedw_o(usedw_sa),
    .overflow_o(ovf_sa), .underflow_o(unf_sa)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, last returned word, error pulses.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  function automatic logic [5:0] exp_flags();
    int sz;
    sz = mq.size();
    return {sz == 0, sz == DEPTH, sz >= AFL, sz <= AEL, m_ovf, m_unf};
  endfunction

  task automatic drive(input logic w, input logic [DW-1:0] d,
                       input logic r, input logic [SW-1:0] s);
    wr = w; wrdata = d; rd = r; skip = s;
  endtask

  // Advance one clock edge, apply the model rules to the inputs seen at it.
  task automatic cycle();
    int  sz, n;
    bit  racc, wacc;
    @(posedge clk);
    if (!srst) begin
      mq.delete(); m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      sz   = mq.size();
      racc = rd && (sz != 0);
      n    = 0;
      if (racc) n = ((int'(skip) + 1) < sz) ? (int'(skip) + 1) : sz;
      wacc  = wr && ((sz != DEPTH) || racc);
      m_ovf = wr && !wacc;
      m_unf = rd && (sz == 0);
      if (racc) m_rd = mq[0];
      repeat (n) void'(mq.pop_front());
      if (wacc) mq.push_back(wrdata);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, '0);
    srst = 1'b0;
    cycle();
    srst = 1'b1;
  endtask

  task automatic test_reset();
    drive(1, 8'hEE, 1, 2'd3);
    srst = 1'b0;
    cycle();
    srst = 1'b1;
    drive(0, '0, 0, '0);
    checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL reset_usedw act=%0d exp=0", usedw); end
    checks++; if (flags !== 6'b100100) begin errors++; $display("FAIL reset_flags act=%b exp=100100", flags); end
    checks++; if (rddata !== 8'h00) begin errors++; $display("FAIL reset_rddata act=%h exp=00", rddata); end
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = DW'((i + 1) * 8'h11);
      drive(1, d, 0, '0);
      cycle();
      checks++; if (usedw !== 3'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL fill_usedw[%0d] act=%0d exp=%0d", i, usedw, (i < 4) ? i + 1 : 4); end
      checks++; if (flags !== exp_flags()) begin errors++; $display("FAIL fill_flags[%0d] act=%b exp=%b", i, flags, exp_flags()); end
    end
    drive(0, '0, 0, '0);
    cycle();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_len act=%b exp=0", ovf); end
  endtask

  task automatic test_skip_read();
    drive(0, '0, 1, 2'd1);
    cycle();
    checks++; if (rddata !== 8'h11) begin errors++; $display("FAIL skip1_data act=%h exp=11", rddata); end
    checks++; if (usedw !== 3'd2) begin errors++; $display("FAIL skip1_usedw act=%0d exp=2", usedw); end
    drive(0, '0, 1, 2'd0);
    cycle();
    checks++; if (rddata !== 8'h33) begin errors++; $display("FAIL skip0_data act=%h exp=33", rddata); end
    checks++; if (usedw !== 3'd1) begin errors++; $display("FAIL skip0_usedw act=%0d exp=1", usedw); end
    drive(0, '0, 0, '0);
  endtask

  task automatic test_clamped_skip();
    do_reset();
    drive(1, 8'h33, 0, '0); cycle();
    drive(1, 8'h44, 0, '0); cycle();
    drive(0, '0, 1, 2'd3);
    cycle();
    checks++; if (rddata !== 8'h33) begin errors++; $display("FAIL clamp_data act=%h exp=33", rddata); end
    checks++; if (usedw !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL clamp_drain act=%0d/%b exp=0/1", usedw, empty); end
    drive(0, '0, 1, 2'd0);
    cycle();
    checks++; if (unf !== 1'b1 || rddata !== 8'h33) begin errors++; $display("FAIL underflow act=%b/%h exp=1/33", unf, rddata); end
    drive(0, '0, 0, '0);
    cycle();
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_pulse_len act=%b exp=0", unf); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] first;
    do_reset();
    first = DW'($urandom);
    drive(1, first, 0, '0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, DW'($urandom), 0, '0); cycle();
    end
    drive(1, 8'h99, 1, 2'd0);
    cycle();
    checks++; if (usedw !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL full_rw act=%0d/%b exp=4/0", usedw, ovf); end
    checks++; if (rddata !== first) begin errors++; $display("FAIL full_rw_data act=%h exp=%h", rddata, first); end
    do_reset();
    drive(1, 8'h77, 1, 2'd0);
    cycle();
    checks++; if (usedw !== 3'd1 || unf !== 1'b1) begin errors++; $display("FAIL empty_rw act=%0d/%b exp=1/1", usedw, unf); end
    drive(0, '0, 0, '0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      drive(i < 16, DW'(i), i > 0, 2'd0);
      cycle();
      if (i > 0) begin
        checks++; if (rddata !== DW'(i - 1)) begin errors++; $display("FAIL wrap_data[%0d] act=%h exp=%h", i, rddata, DW'(i - 1)); end
      end
      checks++; if (usedw > 3'd1) begin errors++; $display("FAIL wrap_usedw[%0d] act=%0d exp<=1", i, usedw); end
    end
    drive(0, '0, 0, '0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, DW'(8'hC0 + i), 0, '0); cycle();
    end
    drive(0, '0, 1, 2'd0); cycle();
    checks++; if (usedw !== 3'd2 || rddata !== 8'hC0) begin errors++; $display("FAIL pre_reset act=%0d/%h exp=2/c0", usedw, rddata); end
    drive(1, 8'hC3, 0, '0); cycle();
    drive(1, 8'hDD, 1, 2'd0);
    srst = 1'b0;
    cycle();
    srst = 1'b1;
    drive(0, '0, 0, '0);
    checks++; if (usedw !== 3'd0 || empty !== 1'b1 || rddata !== 8'h00) begin errors++; $display("FAIL mid_reset act=%0d/%b/%h exp=0/1/00", usedw, empty, rddata); end
  endtask

  task automatic test_showahead();
    drive(1, 8'hA5, 0, '0);
    cycle();
    drive(0, '0, 0, '0);
    checks++; if (rddata_sa !== 8'hA5 || empty_sa !== 1'b0) begin errors++; $display("FAIL sa_head act=%h/%b exp=a5/0", rddata_sa, empty_sa); end
    drive(1, 8'h5A, 0, '0); cycle();
    drive(0, '0, 1, 2'd0); cycle();
    checks++; if (rddata_sa !== 8'h5A || rddata !== 8'hA5) begin errors++; $display("FAIL sa_pop act=%h/%h exp=5a/a5", rddata_sa, rddata); end
    drive(0, '0, 0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) == 0, SW'($urandom));
      srst = ($urandom_range(0, 49) != 0);
      cycle();
      checks++; if (usedw !== 3'(mq.size()) || flags !== exp_flags()) begin errors++; $display("FAIL rnd_status[%0d] act=%0d/%b exp=%0d/%b", i, usedw, flags, mq.size(), exp_flags()); end
      checks++; if (rddata !== m_rd) begin errors++; $display("FAIL rnd_rddata[%0d] act=%h exp=%h", i, rddata, m_rd); end
      checks++; if (usedw_sa !== 3'(mq.size()) || flags_sa !== exp_flags()) begin errors++; $display("FAIL rnd_sa_status[%0d] act=%0d/%b exp=%0d/%b", i, usedw_sa, flags_sa, mq.size(), exp_flags()); end
      if (mq.size() != 0) begin
        checks++; if (rddata_sa !== mq[0]) begin errors++; $display("FAIL rnd_sa_head[%0d] act=%h exp=%h", i, rddata_sa, mq[0]); end
      end
    end
    srst = 1'b1;
    drive(0, '0, 0, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_overflow();
    test_skip_read();
    test_clamped_skip();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_showahead();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
